// File: rtl/lsu_bus.sv
// lsu_bus: load/store unit between the execute stage and a req/gnt/rvalid data port.
// Ports: clk_i/rst_i (sync, active-high); core side req_*_i / req_ready_o / rsp_*_o;
//        memory side d_req_o, d_gnt_i, d_we_o, d_addr_o, d_be_o, d_wdata_o, d_rvalid_i, d_rdata_i.
// Latency: zero-wait store 2, zero-wait load 3, error without bus access 1 cycle after accept.
// Backpressure: one transaction outstanding; req_ready_o is high only in IDLE.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of
// issuing them with the offset rounded down to the access size.
module lsu_bus #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              d_req_o,
  input  logic              d_gnt_i,
  output logic              d_we_o,
  output logic [ADDR_W-1:0] d_addr_o,
  output logic [DATA_W/8-1:0] d_be_o,
  output logic [DATA_W-1:0] d_wdata_o,
  input  logic              d_rvalid_i,
  input  logic [DATA_W-1:0] d_rdata_i
);

  localparam int NB    = DATA_W / 8;
  localparam int OB    = $clog2(NB);
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [OB-1:0]       off_q, off_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NB-1:0]       be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Request decode: size-dependent alignment mask, byte-enable base mask, replicated data.
  logic [1:0]          in_size;
  logic [OB-1:0]       in_off, in_off_f, align_mask;
  logic [NB-1:0]       be_mask;
  logic [DATA_W-1:0]   rep_wdata;
  logic                illegal;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                misalign;
`endif

  always_comb begin
    in_size = req_funct3_i[1:0];
    in_off  = req_addr_i[OB-1:0];
    case (in_size)
      2'd0: begin
        align_mask = OB'(0);
        be_mask    = NB'(1);
        rep_wdata  = {NB{req_wdata_i[7:0]}};
      end
      2'd1: begin
        align_mask = OB'(1);
        be_mask    = NB'(3);
        rep_wdata  = {(NB/2){req_wdata_i[15:0]}};
      end
      2'd2: begin
        align_mask = OB'(3);
        be_mask    = NB'(15);
        rep_wdata  = {(DATA_W/32){req_wdata_i[31:0]}};
      end
      default: begin
        align_mask = OB'(7);
        be_mask    = NB'(255);
        rep_wdata  = req_wdata_i;
      end
    endcase
    illegal  = (DATA_W == 32) && (in_size == 2'd3);
    // Rounding the offset down is a no-op for aligned accesses.
    in_off_f = in_off & ~align_mask;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (in_off & align_mask) != '0;
`endif

  // Load extraction from the registered (possibly rounded) offset.
  logic [DATA_W-1:0] shifted, ext;
  always_comb begin
    shifted = d_rdata_i >> {off_q, 3'b000};
    ext     = shifted;
    case (size_q)
      2'd0: if (uns_q) ext = DATA_W'(shifted[7:0]);
            else       ext = DATA_W'($signed(shifted[7:0]));
      2'd1: if (uns_q) ext = DATA_W'(shifted[15:0]);
            else       ext = DATA_W'($signed(shifted[15:0]));
      2'd2: if (uns_q) ext = DATA_W'(shifted[31:0]);
            else       ext = DATA_W'($signed(shifted[31:0]));
      default: ext = shifted;
    endcase
  end

  logic timeout;
  assign timeout = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC));

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = in_size;
          uns_d   = req_funct3_i[2];
          off_d   = in_off_f;
          addr_d  = {req_addr_i[ADDR_W-1:OB], {OB{1'b0}}};
          be_d    = be_mask << in_off_f;
          wdata_d = rep_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          if (illegal) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
`ifdef LSU_MISALIGN_TRAP_EN
          else if (misalign) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
`endif
          else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // Timeout wins over a grant arriving in the same cycle: d_req_o is already low.
        if (timeout) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (d_gnt_i) begin
          cnt_d   = '0;
          state_d = we_q ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (d_rvalid_i) begin
          rdata_d = ext;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs are masked by rst_i so they are low for the whole reset period.
  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign d_req_o     = (state_q == REQ) && !timeout && !rst_i;
  assign rsp_valid_o = (state_q == RESP) && !rst_i;
  assign rsp_err_o   = (state_q == RESP) && err_q && !rst_i;
  assign rsp_rdata_o = rdata_q;
  assign d_we_o      = we_q;
  assign d_addr_o    = addr_q;
  assign d_be_o      = be_q;
  assign d_wdata_o   = wdata_q;

endmodule
